// File: rtl/hs_link_if.sv
// Link-level bundle between the traffic driver and hs_link: source/sink strobes in, status out.
// DUT side uses the slave modport; the driving side uses master.
interface hs_link_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              valid_in;
  logic              ready_in;
  logic [DATA_W-1:0] result;
  logic [15:0]       beat_cnt;
  logic [LVL_W-1:0]  level;
  logic              full;
  logic              empty;
  logic              stall;

  modport slave (
    input  valid_in, ready_in,
    output result, beat_cnt, level, full, empty, stall
  );

  modport master (
    output valid_in, ready_in,
    input  result, beat_cnt, level, full, empty, stall
  );
endinterface

// File: rtl/hs_link.sv
// Sequence source -> DEPTH-entry FIFO -> sink register, linked by valid/ready; result 2 edges after push.
// Source is refused only when the FIFO is full and not popping that cycle; refusal shows on stall one cycle later.
module hs_link #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int MODE   = 0
) (
  input  logic   sys_clk,
  input  logic   rst,
  hs_link_if.slave lnk
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [DATA_W-1:0] r_seq;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [DATA_W-1:0] r_result;
  logic [15:0]       r_beat_cnt;
  logic              r_stall;

  logic              w_src_vld;
  logic              w_fifo_in_rdy;
  logic              w_fifo_out_vld;
  logic              w_sink_rdy;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_pop_dat;

  // Status comes only from the registered level, so no input-to-status path exists.
  assign w_full         = (r_level == LVL_W'(DEPTH));
  assign w_empty        = (r_level == '0);
  assign w_src_vld      = lnk.valid_in;
  assign w_sink_rdy     = lnk.ready_in;
  assign w_fifo_out_vld = !w_empty;
  assign w_pop          = w_fifo_out_vld && w_sink_rdy;
  assign w_fifo_in_rdy  = !w_full || w_pop;
  assign w_push         = w_src_vld && w_fifo_in_rdy;
  assign w_pop_dat      = r_mem[r_rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_seq;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_seq    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_stall <= w_src_vld && w_full && !w_pop;
      if (w_push) begin
        r_seq    <= r_seq + 1'b1;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_result   <= '0;
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= r_beat_cnt + 16'd1;
      if (MODE == 1) begin
        r_result <= r_result + w_pop_dat;
      end else begin
        r_result <= w_pop_dat;
      end
    end
  end

  assign lnk.result   = r_result;
  assign lnk.beat_cnt = r_beat_cnt;
  assign lnk.level    = r_level;
  assign lnk.full     = w_full;
  assign lnk.empty    = w_empty;
  assign lnk.stall    = r_stall;
endmodule

// File: doc/hs_link.md
HS_LINK -- requirements
Module: hs_link

Interface
REQ-001 SHALL have parameter DATA_W, default 8: beat data width, >=2.
REQ-002 SHALL have parameter DEPTH, default 4: buffer entries, power of two, >=2.
REQ-003 SHALL have parameter MODE, default 0: 0 = result holds last beat, 1 = result accumulates beats.
REQ-004 SHALL have port sys_clk  in  1: single clock, all state on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-006 SHALL have port valid_in  in  1: source request to generate one beat per cycle.
REQ-007 SHALL have port ready_in  in  1: sink willing to accept one beat per cycle.
REQ-008 SHALL have port result  out  DATA_W: sink result register.
REQ-009 SHALL have port beat_cnt  out  16: count of beats delivered to sink.
REQ-010 SHALL have port level  out  clog2(DEPTH)+1: current buffer occupancy.
REQ-011 SHALL have port full  out  1: level == DEPTH.
REQ-012 SHALL have port empty  out  1: level == 0.
REQ-013 SHALL have port stall  out  1: registered; source request refused in the previous cycle.

Function
REQ-014 SHALL contain a source, a DEPTH-entry FIFO and a sink, all linked by internal valid/ready handshakes; a beat transfers only when valid and ready are both high on the same edge.
REQ-015 Source valid SHALL equal valid_in; source data SHALL be a DATA_W sequence counter seq.
REQ-016 Push SHALL occur when valid_in && (!full || pop); on push seq SHALL increment mod 2^DATA_W, else hold.
REQ-017 Pop SHALL occur when ready_in && !empty.
REQ-018 Simultaneous push and pop SHALL leave level unchanged, including when full; stall SHALL NOT assert in that case.
REQ-019 valid_in && full && !pop SHALL refuse the push: no write, seq holds, stall=1 on the next cycle.
REQ-020 Pushed data SHALL be available for pop on the next edge; minimum latency from push edge to result update is 2 edges.
REQ-021 On pop: beat_cnt SHALL increment, wrapping 0xFFFF->0; with MODE=0, result <= popped data; with MODE=1, result <= (result + popped data) mod 2^DATA_W.
REQ-022 FIFO read/write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow below 0.
REQ-023 full, empty and level SHALL be registered-consistent, with no combinational path from valid_in or ready_in.
REQ-024 FIFO order SHALL be preserved: beats reach the sink in seq order with no loss or duplication.

Reset
REQ-025 While rst=1 at an edge: seq, pointers, level, result, beat_cnt and stall SHALL all be 0; empty=1 and full=0.
REQ-026 Reset mid-operation SHALL flush the buffer; pending beats are discarded and not delivered.
REQ-027 The first push after reset SHALL carry data 0.

Verification
REQ-028 Fill: with DATA_W=8, DEPTH=4, drive valid_in=1, ready_in=0 for 6 cycles -> data 0..3 stored, level=4, full=1, stall=1 for the last 2 cycles, seq=4.
REQ-029 Drain: after the fill, drive valid_in=0, ready_in=1 for 5 cycles -> pops 0,1,2,3; MODE=0 result=3; beat_cnt=4; empty=1; no fifth pop.
REQ-030 Streaming: from reset, hold valid_in=1, ready_in=1 -> level stays 1 after the first edge; result takes values 0,1,2,... one per cycle, starting at edge 2.
REQ-031 Full pass-through: at level=4, drive both inputs high for 3 cycles -> level stays 4, stall=0, 3 beats delivered in order.
REQ-032 Wrap and accumulate: with MODE=1 and DATA_W=8, stream 257 beats -> the beat after 255 carries 0; result = (sum of 0..255 + 0) mod 256 = 128; beat_cnt=257.
REQ-033 Reset mid-stream: assert rst for 1 cycle at level=3 -> next cycle all outputs are 0, empty=1, and the next delivered beat is 0.
